// File: rtl/rd_ctrl_pkg.sv
// Shared types and helpers for the burst packet read controller.
package rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } rd_state_e;

  // Length of the next burst: whatever is left, capped at the burst limit.
  function automatic int unsigned min_len(input longint unsigned rem,
                                          input int unsigned burst_max);
    return (rem < 64'(burst_max)) ? 32'(rem) : burst_max;
  endfunction

endpackage

// File: rtl/rd_ctrl_credit.sv
// Outstanding-word counter; grants a launch only if the burst fits in the
// remaining read credit.
module rd_ctrl_credit #(
  parameter int unsigned OUTST_MAX = 16,
  parameter int unsigned LEN_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add,
  input  logic [LEN_W-1:0] add_len,
  input  logic             sub,
  input  logic [LEN_W-1:0] req_len,
  output logic             credit_ok,
  output logic             outst_zero
);

  localparam int unsigned CNT_W = $clog2(OUTST_MAX + 1);

  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W:0]   need;

  always_comb begin
    outst_d = outst_q;
    if (add) outst_d = outst_d + CNT_W'(add_len);
    if (sub && (outst_q != '0 || add)) outst_d = outst_d - CNT_W'(1);
    need      = {1'b0, outst_q} + (CNT_W+1)'(req_len);
    credit_ok = need <= (CNT_W+1)'(OUTST_MAX);
  end

  assign outst_zero = (outst_q == '0);

  always_ff @(posedge clk) begin
    if (reset) outst_q <= '0;
    else       outst_q <= outst_d;
  end

endmodule

// File: rtl/rd_ctrl_burst.sv
// Packet read controller: fetches [pkt_begin, pkt_end) with pipelined
// Avalon-MM burst reads and pushes every returned word into the capture FIFO.
module rd_ctrl_burst
  import rd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned OUTST_MAX = 16,
  parameter int unsigned BYTES     = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_ctrl,
  input  logic                         abort,
  input  logic [ADDR_W-1:0]            pkt_begin,
  input  logic [ADDR_W-1:0]            pkt_end,
  input  logic                         almost_full,
  output logic                         rd_ctrl_rdy,
  output logic                         done,
  output logic                         err,
  output logic [ADDR_W-1:0]            words_read,
  output logic [DATA_W-1:0]            fifo_in,
  output logic                         fifo_wr,
  output logic [ADDR_W-1:0]            address,
  output logic                         read,
  output logic [$clog2(BURST_MAX):0]   burstcount,
  input  logic                         waitrequest,
  input  logic [DATA_W-1:0]            readdata,
  input  logic                         readdatavalid
);

  localparam int unsigned BC_W  = $clog2(BURST_MAX) + 1;
  localparam int unsigned LSB_W = $clog2(BYTES);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              abort_seen_q, abort_seen_d;
  logic              read_q, read_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [DATA_W-1:0] fifo_in_q, fifo_in_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic              err_q, err_d;

  logic              busy, abort_now, accept, rdv, bad_cmd;
  logic              credit_ok, outst_zero;
  logic [BC_W-1:0]   len;
  logic [ADDR_W-1:0] span;

  rd_ctrl_credit #(
    .OUTST_MAX (OUTST_MAX),
    .LEN_W     (BC_W)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .add        (accept),
    .add_len    (bc_q),
    .sub        (rdv),
    .req_len    (len),
    .credit_ok  (credit_ok),
    .outst_zero (outst_zero)
  );

  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == DRAIN);
    // An abort in the same cycle as a returning word already drops that word.
    abort_now = abort_seen_q | (busy & abort);
    accept    = read_q & ~waitrequest;
    rdv       = busy & readdatavalid;
    len       = BC_W'(min_len(64'(rem_q), BURST_MAX));
    span      = pkt_end - pkt_begin;
    bad_cmd   = (pkt_end < pkt_begin)
             || ((pkt_begin & ADDR_W'(BYTES - 1)) != '0)
             || ((pkt_end   & ADDR_W'(BYTES - 1)) != '0);

    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    words_d      = words_q;
    abort_seen_d = abort_seen_q;
    read_d       = read_q;
    bc_d         = bc_q;
    err_d        = 1'b0;
    fifo_wr_d    = rdv & ~abort_now;
    fifo_in_d    = fifo_wr_d ? readdata : fifo_in_q;
    if (fifo_wr_d) words_d = words_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (rd_ctrl) begin
          if (bad_cmd) begin
            err_d = 1'b1;
          end else begin
            addr_d       = pkt_begin;
            rem_d        = span >> LSB_W;
            words_d      = '0;
            abort_seen_d = 1'b0;
            state_d      = (span == '0) ? FINISH : ISSUE;
          end
        end
      end
      ISSUE: begin
        abort_seen_d = abort_now;
        // Address, burstcount and read stay registered until accepted, so a
        // stalled request is never withdrawn by almost_full or abort.
        if (accept) begin
          addr_d = addr_q + (ADDR_W'(bc_q) << LSB_W);
          rem_d  = rem_q - ADDR_W'(bc_q);
          read_d = 1'b0;
          bc_d   = '0;
          if (rem_d == '0 || abort_now) state_d = DRAIN;
        end else if (!read_q) begin
          if (rem_q == '0 || abort_now) begin
            state_d = DRAIN;
          end else if (!almost_full && credit_ok) begin
            read_d = 1'b1;
            bc_d   = len;
          end
        end
      end
      DRAIN: begin
        abort_seen_d = abort_now;
        if (outst_zero) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      words_q      <= '0;
      abort_seen_q <= 1'b0;
      read_q       <= 1'b0;
      bc_q         <= '0;
      fifo_in_q    <= '0;
      fifo_wr_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      words_q      <= words_d;
      abort_seen_q <= abort_seen_d;
      read_q       <= read_d;
      bc_q         <= bc_d;
      fifo_in_q    <= fifo_in_d;
      fifo_wr_q    <= fifo_wr_d;
      err_q        <= err_d;
    end
  end

  assign rd_ctrl_rdy = (state_q == IDLE);
  assign done        = (state_q == FINISH);
  assign err         = err_q;
  assign words_read  = words_q;
  assign fifo_in     = fifo_in_q;
  assign fifo_wr     = fifo_wr_q;
  assign address     = addr_q;
  assign read        = read_q;
  assign burstcount  = bc_q;

endmodule

// File: tb/tb_rd_ctrl_burst.sv
// Directed bench for rd_ctrl_burst with a pipelined Avalon-MM slave model
// that returns address/4 + 10 for every word.
module tb_rd_ctrl_burst;

  logic        clk, reset, rd_ctrl, abort, almost_full;
  logic [31:0] pkt_begin, pkt_end;
  logic        rd_ctrl_rdy, done, err, fifo_wr, read;
  logic [31:0] words_read, fifo_in, address, readdata;
  logic [3:0]  burstcount;
  logic        waitrequest, readdatavalid;

  rd_ctrl_burst #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .BURST_MAX (8),
    .OUTST_MAX (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_ctrl       (rd_ctrl),
    .abort         (abort),
    .pkt_begin     (pkt_begin),
    .pkt_end       (pkt_end),
    .almost_full   (almost_full),
    .rd_ctrl_rdy   (rd_ctrl_rdy),
    .done          (done),
    .err           (err),
    .words_read    (words_read),
    .fifo_in       (fifo_in),
    .fifo_wr       (fifo_wr),
    .address       (address),
    .read          (read),
    .burstcount    (burstcount),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model state
  logic [31:0] slv_q[$];
  logic [31:0] acc_addr[$];
  logic [3:0]  acc_bc[$];
  int unsigned n_acc, stall_idx, stall_left, max_fly, last_rdv_edge;
  logic [31:0] st_addr;
  logic [3:0]  st_bc;

  // Monitor state
  logic [31:0] got[$];
  int unsigned done_cnt, err_cnt, done_cyc;
  bit          read_seen, rdy_low;

  initial begin
    readdatavalid = 1'b0;
    waitrequest   = 1'b0;
    readdata      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        slv_q.delete();
        readdatavalid = 1'b0;
        waitrequest   = 1'b0;
      end else begin
        if (slv_q.size() > 0) begin
          readdata      = slv_q.pop_front();
          readdatavalid = 1'b1;
          last_rdv_edge = cyc + 1;
        end else begin
          readdatavalid = 1'b0;
        end
        if (read) begin
          if (n_acc == stall_idx && stall_left > 0) begin
            if (stall_left == 5) begin
              st_addr = address;
              st_bc   = burstcount;
            end else begin
              check_eq("stall_address", address, st_addr);
              check_eq("stall_burstcount", burstcount, st_bc);
            end
            waitrequest = 1'b1;
            stall_left--;
          end else begin
            waitrequest = 1'b0;
            for (int unsigned i = 0; i < burstcount; i++)
              slv_q.push_back((address >> 2) + i + 10);
            acc_addr.push_back(address);
            acc_bc.push_back(burstcount);
            n_acc++;
            if (slv_q.size() > max_fly) max_fly = slv_q.size();
          end
        end else begin
          waitrequest = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wr) got.push_back(fifo_in);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (read) read_seen = 1'b1;
      if (!rd_ctrl_rdy) rdy_low = 1'b1;
    end
  end

  task automatic clear_stats();
    got.delete();
    acc_addr.delete();
    acc_bc.delete();
    slv_q.delete();
    n_acc = 0; max_fly = 0; done_cnt = 0; err_cnt = 0;
    read_seen = 1'b0; rdy_low = 1'b0;
    stall_idx = 99; stall_left = 0;
  endtask

  task automatic run_xfer(input logic [31:0] b, input logic [31:0] e);
    bit finished;
    finished  = 1'b0;
    pkt_begin = b;
    pkt_end   = e;
    rd_ctrl   = 1'b1;
    @(negedge clk);
    rd_ctrl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done || err) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("xfer_finished", finished, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Returns at the negedge on which the slave registers the n-th acceptance.
  task automatic wait_acc(input int unsigned n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (n_acc >= n) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("wait_accept", seen, 1'b1);
  endtask

  task automatic check_seq(input string name, input int unsigned n, input int unsigned first);
    check_eq({name, "_count"}, got.size(), n);
    for (int unsigned i = 0; i < n && i < got.size(); i++)
      check_eq($sformatf("%s_word%0d", name, i), got[i], first + i);
  endtask

  task automatic check_19_bursts(input string name);
    check_eq({name, "_nbursts"}, acc_addr.size(), 3);
    if (acc_addr.size() == 3) begin
      check_eq({name, "_b0_addr"}, acc_addr[0], 32'h00);
      check_eq({name, "_b0_len"},  acc_bc[0],   8);
      check_eq({name, "_b1_addr"}, acc_addr[1], 32'h20);
      check_eq({name, "_b1_len"},  acc_bc[1],   8);
      check_eq({name, "_b2_addr"}, acc_addr[2], 32'h40);
      check_eq({name, "_b2_len"},  acc_bc[2],   3);
    end
  endtask

  int unsigned rd_during_af;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rd_ctrl = 1'b0; abort = 1'b0; almost_full = 1'b0;
    pkt_begin = '0; pkt_end = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", rd_ctrl_rdy, 1'b1);
    check_eq("rst_read", read, 1'b0);
    check_eq("rst_burstcount", burstcount, 4'd0);
    check_eq("rst_address", address, 32'd0);
    check_eq("rst_fifo_wr", fifo_wr, 1'b0);
    check_eq("rst_fifo_in", fifo_in, 32'd0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_words", words_read, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single burst of 8
    clear_stats();
    run_xfer(32'h0, 32'h20);
    check_seq("one_burst", 8, 10);
    check_eq("one_words", words_read, 8);
    check_eq("one_done", done_cnt, 1);
    check_eq("one_nbursts", acc_addr.size(), 1);
    check_eq("one_done_lat", done_cyc, last_rdv_edge + 1);
    check_eq("one_rdy_back", rd_ctrl_rdy, 1'b1);

    // 19 words: 8 + 8 + 3
    clear_stats();
    run_xfer(32'h0, 32'h4C);
    check_seq("b19", 19, 10);
    check_eq("b19_words", words_read, 19);
    check_19_bursts("b19");

    // Same range with the second burst stalled for 5 cycles
    clear_stats();
    stall_idx = 1; stall_left = 5;
    run_xfer(32'h0, 32'h4C);
    check_seq("stall", 19, 10);
    check_eq("stall_used", stall_left, 0);
    check_19_bursts("stall");

    // almost_full after the first burst, 32 words
    clear_stats();
    rd_during_af = 0;
    fork
      run_xfer(32'h0, 32'h80);
      begin
        wait_acc(1);
        @(negedge clk);
        almost_full = 1'b1;
        repeat (8) begin
          @(negedge clk);
          if (read) rd_during_af++;
        end
        almost_full = 1'b0;
      end
    join
    check_eq("af_no_read", rd_during_af, 0);
    check_seq("af", 32, 10);
    check_eq("af_words", words_read, 32);
    check_eq("af_nbursts", acc_addr.size(), 4);
    check_eq("af_outst_le16", max_fly <= 16, 1'b1);

    // abort right after the first burst is accepted
    clear_stats();
    fork
      run_xfer(32'h0, 32'h80);
      begin
        wait_acc(1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    join
    check_eq("abort_nbursts", acc_addr.size(), 1);
    check_eq("abort_written", got.size(), 0);
    check_eq("abort_words", words_read, 0);
    check_eq("abort_done", done_cnt, 1);
    check_eq("abort_done_lat", done_cyc, last_rdv_edge + 1);

    // Rejected commands
    clear_stats();
    run_xfer(32'h10, 32'h08);
    run_xfer(32'h02, 32'h10);
    check_eq("err_pulses", err_cnt, 2);
    check_eq("err_no_read", read_seen, 1'b0);
    check_eq("err_rdy_held", rdy_low, 1'b0);
    check_eq("err_no_done", done_cnt, 0);

    // Reset in the middle of a transfer
    clear_stats();
    pkt_begin = 32'h0; pkt_end = 32'h80; rd_ctrl = 1'b1;
    @(negedge clk);
    rd_ctrl = 1'b0;
    wait_acc(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rdy", rd_ctrl_rdy, 1'b1);
    check_eq("mid_rst_read", read, 1'b0);
    check_eq("mid_rst_words", words_read, 32'd0);
    check_eq("mid_rst_address", address, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-length command
    clear_stats();
    run_xfer(32'h40, 32'h40);
    check_eq("zero_done", done_cnt, 1);
    check_eq("zero_err", err_cnt, 0);
    check_eq("zero_no_read", read_seen, 1'b0);
    check_eq("zero_words", words_read, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
